alu_arbiter: RTL

- Shares one combinational ALU (2-bit op: add=00, subtract=01, or=10, and=11; 32-bit signed a/b; sign/overflow/zero status) between NUM_REQ requesters.
- Round-robin arbitration, operand capture and a valid/ready response channel per requester.
- Drives the external ALU from registered operands, so the ALU path is never combinational from requester inputs.
- Sits between the issue units and the shared ALU instance.

---
 rtl/alu_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between NUM_REQ issue units.
// Optional performance counters are enabled with `define ALU_ARB_PERF_EN.
module alu_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ALU_WAIT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [2*NUM_REQ-1:0]  req_op,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [31:0]           rsp_result,
  output logic                  rsp_sign,
  output logic                  rsp_overflow,
  output logic                  rsp_zero,
  output logic [1:0]            alu_op,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  input  logic [31:0]           alu_result,
  input  logic                  alu_sign,
  input  logic                  alu_overflow,
  input  logic                  alu_zero
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]           perf_ops,
  output logic [31:0]           perf_stall
`endif
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int WAIT_W = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [IDX_W-1:0]   winner;
  logic               accept;
  logic               rsp_done;
  logic               grant_rsp_ready;
  logic [1:0]         sel_op;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;
  logic [NUM_REQ-1:0] grant_onehot;

  // First valid index at or above ptr, wrapping at NUM_REQ.
  function automatic logic [IDX_W-1:0] pick_winner(input logic [NUM_REQ-1:0] v,
                                                   input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] w;
    logic             found;
    int               idx;
    w     = '0;
    found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && j == idx && v[j]) begin
          found = 1'b1;
          w     = IDX_W'(j);
        end
      end
    end
    return w;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx == IDX_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
    return (g == IDX_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;
  endfunction

  assign winner       = pick_winner(req_valid, rr_ptr);
  assign grant_onehot = onehot(grant);

  always_comb begin
    sel_op          = '0;
    sel_a           = '0;
    sel_b           = '0;
    grant_rsp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDX_W'(i)) begin
        sel_op = req_op[2*i +: 2];
        sel_a  = req_a[32*i +: 32];
        sel_b  = req_b[32*i +: 32];
      end
      if (grant == IDX_W'(i)) grant_rsp_ready = rsp_ready[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // req_ready is gated by rst_n so it reads 0 for the whole reset window.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && |req_valid) begin
          req_ready = onehot(winner);
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (wait_cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        if (grant_rsp_ready) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, ALU wait and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      grant        <= '0;
      wait_cnt     <= '0;
      alu_op       <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      rsp_valid    <= '0;
      rsp_result   <= '0;
      rsp_sign     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
    end else begin
      if (accept) begin
        alu_op   <= sel_op;
        alu_a    <= sel_a;
        alu_b    <= sel_b;
        grant    <= winner;
        wait_cnt <= WAIT_W'(ALU_WAIT - 1);
      end
      if (state == EXEC) begin
        if (wait_cnt == '0) begin
          rsp_result   <= alu_result;
          rsp_sign     <= alu_sign;
          rsp_overflow <= alu_overflow;
          rsp_zero     <= alu_zero;
          rsp_valid    <= grant_onehot;
        end else begin
          wait_cnt <= wait_cnt - 1'b1;
        end
      end
      if (rsp_done) begin
        rsp_valid <= '0;
        rr_ptr    <= next_ptr(grant);
      end
    end
  end

`ifdef ALU_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (rsp_done) perf_ops <= perf_ops + 32'd1;
      if (state == RESP && !grant_rsp_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
